// File: rtl/reg_file_rename.sv
// Architectural register file with a per-register rename (busy/tag) table.
// Retire writes values back; dispatch renames rd to a ROB tag; two operand lookups.
module reg_file_rename #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 rn_en,
    input  logic [4:0]           rn_idx,
    input  logic [TAG_W-1:0]     rn_tag,
    input  logic                 cm_en,
    input  logic [4:0]           cm_idx,
    input  logic [TAG_W-1:0]     cm_tag,
    input  logic [XLEN-1:0]      cm_val,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic                 rs1_ready,
    output logic [XLEN-1:0]      rs1_val,
    output logic                 rs2_ready,
    output logic [XLEN-1:0]      rs2_val,
    output logic [NREG-1:0]      busy_mask
);

    logic [XLEN-1:0]  val_q [NREG];
    logic [XLEN-1:0]  val_d [NREG];
    logic [TAG_W-1:0] tag_q [NREG];
    logic [TAG_W-1:0] tag_d [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic [NREG-1:0]  busy_mask_q, busy_mask_d;

    // Next-state: commit first, then rename (rename wins on same reg), flush clears last.
    always_comb begin
        val_d       = val_q;
        tag_d       = tag_q;
        busy_d      = busy_q;
        if (rdy) begin
            if (cm_en && (cm_idx != 5'd0)) begin
                val_d[cm_idx] = cm_val;
                if (tag_q[cm_idx] == cm_tag) begin
                    busy_d[cm_idx] = 1'b0;
                end
            end
            if (rn_en && (rn_idx != 5'd0) && !flush) begin
                busy_d[rn_idx] = 1'b1;
                tag_d[rn_idx]  = rn_tag;
            end
            if (flush) begin
                busy_d = '0;
            end
        end
        busy_mask_d = busy_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q       <= '{default: '0};
            tag_q       <= '{default: '0};
            busy_q      <= '0;
            busy_mask_q <= '0;
        end else begin
            val_q       <= val_d;
            tag_q       <= tag_d;
            busy_q      <= busy_d;
            busy_mask_q <= busy_mask_d;
        end
    end

    // Operand lookups see pre-rename state; a matching retire this cycle is bypassed.
    always_comb begin
        rs1_ready = 1'b1;
        rs1_val   = '0;
        if (rs1_addr != 5'd0) begin
            if (!busy_q[rs1_addr]) begin
                rs1_val = val_q[rs1_addr];
            end else if (cm_en && (cm_idx == rs1_addr) && (cm_tag == tag_q[rs1_addr])) begin
                rs1_val = cm_val;
            end else begin
                rs1_ready = 1'b0;
                rs1_val   = XLEN'(tag_q[rs1_addr]);
            end
        end
    end

    always_comb begin
        rs2_ready = 1'b1;
        rs2_val   = '0;
        if (rs2_addr != 5'd0) begin
            if (!busy_q[rs2_addr]) begin
                rs2_val = val_q[rs2_addr];
            end else if (cm_en && (cm_idx == rs2_addr) && (cm_tag == tag_q[rs2_addr])) begin
                rs2_val = cm_val;
            end else begin
                rs2_ready = 1'b0;
                rs2_val   = XLEN'(tag_q[rs2_addr]);
            end
        end
    end

    assign busy_mask = busy_mask_q;

endmodule

// File: tb/tb_reg_file_rename.sv
// Bench for reg_file_rename: directed scenarios then random traffic against an array model.
module tb_reg_file_rename;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREG  = 32;
    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rdy, flush, rn_en, cm_en;
    logic [4:0]       rn_idx, cm_idx, rs1_addr, rs2_addr;
    logic [TAG_W-1:0] rn_tag, cm_tag;
    logic [XLEN-1:0]  cm_val;
    logic             rs1_ready, rs2_ready;
    logic [XLEN-1:0]  rs1_val, rs2_val;
    logic [NREG-1:0]  busy_mask;

    reg_file_rename #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .rn_en(rn_en), .rn_idx(rn_idx), .rn_tag(rn_tag),
        .cm_en(cm_en), .cm_idx(cm_idx), .cm_tag(cm_tag), .cm_val(cm_val),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_ready(rs1_ready), .rs1_val(rs1_val),
        .rs2_ready(rs2_ready), .rs2_val(rs2_val),
        .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    // Reference state: what each register holds and which ROB entry owns it.
    logic [XLEN-1:0]  m_val  [NREG];
    bit               m_busy [NREG];
    logic [TAG_W-1:0] m_tag  [NREG];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    function automatic logic [NREG-1:0] model_mask();
        logic [NREG-1:0] m;
        for (int i = 0; i < NREG; i++) m[i] = m_busy[i];
        return m;
    endfunction

    // Expected {ready, value} for a lookup given current model and inputs.
    function automatic logic [XLEN:0] exp_lookup(input logic [4:0] a);
        if (a == 5'd0)            return {1'b1, {XLEN{1'b0}}};
        if (!m_busy[a])           return {1'b1, m_val[a]};
        if (cm_en && cm_idx == a && cm_tag == m_tag[a]) return {1'b1, cm_val};
        return {1'b0, XLEN'(m_tag[a])};
    endfunction

    task automatic model_update();
        if (!rdy) return;
        if (cm_en && cm_idx != 5'd0) begin
            m_val[cm_idx] = cm_val;
            if (m_busy[cm_idx] && m_tag[cm_idx] == cm_tag) m_busy[cm_idx] = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end else if (rn_en && rn_idx != 5'd0) begin
            m_busy[rn_idx] = 1'b1;
            m_tag[rn_idx]  = rn_tag;
        end
    endtask

    task automatic check_outputs();
        logic [XLEN:0] e1, e2;
        e1 = exp_lookup(rs1_addr);
        e2 = exp_lookup(rs2_addr);
        chk("rs1_ready", XLEN'(rs1_ready), XLEN'(e1[XLEN]));
        chk("rs1_val",   rs1_val,          e1[XLEN-1:0]);
        chk("rs2_ready", XLEN'(rs2_ready), XLEN'(e2[XLEN]));
        chk("rs2_val",   rs2_val,          e2[XLEN-1:0]);
        chk("busy_mask", busy_mask,        model_mask());
    endtask

    task automatic settle();
        #1;
        check_outputs();
    endtask

    task automatic clock_step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        clock_step();
    endtask

    task automatic idle();
        rdy = 1'b1; flush = 1'b0;
        rn_en = 1'b0; rn_idx = '0; rn_tag = '0;
        cm_en = 1'b0; cm_idx = '0; cm_tag = '0; cm_val = '0;
    endtask

    task automatic do_rn(input logic [4:0] idx, input logic [TAG_W-1:0] t);
        idle(); rn_en = 1'b1; rn_idx = idx; rn_tag = t;
    endtask

    task automatic do_cm(input logic [4:0] idx, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        idle(); cm_en = 1'b1; cm_idx = idx; cm_tag = t; cm_val = v;
    endtask

    // Reset asserted between edges must clear outputs without waiting for a clock.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs();
        chk("rst_busy_mask", busy_mask, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rs1_addr = '0; rs2_addr = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        rs1_addr = 5'd5; rs2_addr = 5'd0;
        settle();
        chk("reset_rs1_ready", XLEN'(rs1_ready), 32'd1);
        chk("reset_rs1_val", rs1_val, 32'd0);
        chk("reset_busy_mask", busy_mask, '0);
        clock_step();

        // Rename, then retire with same-cycle bypass
        do_rn(5'd5, 4'd3); cycle();
        idle(); settle();
        chk("rn_x5_ready", XLEN'(rs1_ready), 32'd0);
        chk("rn_x5_tag", rs1_val, 32'h3);
        clock_step();
        do_cm(5'd5, 4'd3, 32'hDEADBEEF); settle();
        chk("bypass_ready", XLEN'(rs1_ready), 32'd1);
        chk("bypass_val", rs1_val, 32'hDEADBEEF);
        clock_step();
        idle(); settle();
        chk("stored_val", rs1_val, 32'hDEADBEEF);
        clock_step();

        // Newer renamer keeps register busy past an older retire
        do_rn(5'd5, 4'd3); cycle();
        do_rn(5'd5, 4'd7); cycle();
        do_cm(5'd5, 4'd3, 32'h11); cycle();
        idle(); settle();
        chk("newer_owner_tag", rs1_val, 32'h7);
        clock_step();
        do_cm(5'd5, 4'd7, 32'h22); cycle();
        idle(); settle();
        chk("newer_retire_val", rs1_val, 32'h22);
        clock_step();

        // Same-cycle commit and rename on x6
        rs1_addr = 5'd6;
        do_cm(5'd6, 4'd2, 32'h5); rn_en = 1'b1; rn_idx = 5'd6; rn_tag = 4'd9; cycle();
        idle(); settle();
        chk("same_cycle_tag", rs1_val, 32'h9);
        clock_step();
        do_cm(5'd6, 4'd9, 32'h6); cycle();
        idle(); settle();
        chk("same_cycle_final", rs1_val, 32'h6);
        clock_step();

        // x0 is never written or renamed
        rs1_addr = 5'd0;
        do_rn(5'd0, 4'd1); cycle();
        do_cm(5'd0, 4'd1, 32'h5); cycle();
        idle(); settle();
        chk("x0_val", rs1_val, 32'd0);
        chk("x0_busy", XLEN'(busy_mask[0]), 32'd0);
        clock_step();

        // Flush drops all mappings and ignores concurrent rename
        do_rn(5'd1, 4'd1); cycle();
        do_rn(5'd2, 4'd2); cycle();
        do_rn(5'd3, 4'd3); cycle();
        idle(); settle();
        chk("pre_flush_mask", busy_mask, 32'hE);
        clock_step();
        do_rn(5'd4, 4'd4); flush = 1'b1; cycle();
        idle(); settle();
        chk("post_flush_mask", busy_mask, 32'h0);
        clock_step();

        // rdy low freezes state
        rs1_addr = 5'd7;
        do_rn(5'd7, 4'd5); rdy = 1'b0; cycle();
        do_cm(5'd8, 4'd0, 32'h99); rdy = 1'b0; rs2_addr = 5'd8; cycle();
        idle(); settle();
        chk("rdy_hold_mask", busy_mask, 32'h0);
        chk("rdy_hold_val", rs2_val, 32'h0);
        clock_step();

        // Asynchronous reset mid-run
        do_rn(5'd9, 4'd6); cycle();
        do_cm(5'd10, 4'd0, 32'h1234); cycle();
        idle(); rs1_addr = 5'd9; rs2_addr = 5'd10;
        async_reset();

        // Random traffic over a small register window for frequent collisions
        for (int i = 0; i < 3000; i++) begin
            rdy    = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 24) == 0);
            rn_en  = 1'($urandom_range(0, 1));
            rn_idx = 5'($urandom_range(0, 7));
            rn_tag = TAG_W'($urandom);
            cm_en  = 1'($urandom_range(0, 1));
            cm_idx = 5'($urandom_range(0, 7));
            cm_tag = ($urandom_range(0, 3) != 0) ? m_tag[cm_idx] : TAG_W'($urandom);
            cm_val = $urandom;
            rs1_addr = ($urandom_range(0, 1) != 0) ? cm_idx : 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 31));
            if (i == 1500) begin
                async_reset();
            end else begin
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
